// File: rtl/dtree_pkg.sv
// Shared types and constants for the decision-tree page sequencer.
//   state_e   : sequencer FSM states
//   page_e    : instruction ROM page select (ROOT/LEFT/RIGHT)
//   BRANCH0   : instruction forced onto the core while a page switch settles
//   LABEL_*   : class label encodings
//   wd_active : states in which the watchdog counts
package dtree_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CRST,
        S_PAGING,
        S_PAGE_RUN,
        S_START,
        S_OTH_0,
        S_OTH_1,
        S_OTH_2,
        S_OP_0,
        S_OP_1,
        S_OP_2,
        S_FEAT_WAIT,
        S_FEAT_REQ,
        S_FEAT_FETCH,
        S_DONE,
        S_ERR
    } state_e;

    typedef enum logic [1:0] {
        PAGE_ROOT  = 2'd0,
        PAGE_LEFT  = 2'd1,
        PAGE_RIGHT = 2'd2
    } page_e;

    localparam logic [7:0] BRANCH0 = 8'b1_000_0000;

    localparam logic [1:0] LABEL_0 = 2'd0;
    localparam logic [1:0] LABEL_1 = 2'd1;
    localparam logic [1:0] LABEL_2 = 2'd2;
    localparam logic [1:0] LABEL_3 = 2'd3;

    // Waiting for a user start is not a hang, so those states are exempt.
    function automatic logic wd_active(input state_e s);
        return !(s inside {S_IDLE, S_DONE, S_ERR});
    endfunction

endpackage

// File: rtl/dtree_page_sequencer_if.sv
// Bus bundle between the page sequencer, the decision-tree core and the
// feature source.
//   master : sequencer side (drives core control, feature request, label)
//   slave  : core / feature-source side
interface dtree_page_sequencer_if #(
    parameter int DATA_LEN = 4,
    parameter int PC_LEN   = 7
);
    logic                start;
    logic [DATA_LEN-1:0] OPORT;
    logic [PC_LEN-1:0]   PC;
    logic                core_rstn;
    logic [1:0]          page_sel;
    logic                instr_override;
    logic [DATA_LEN-1:0] IPORT;
    logic                feature_req;
    logic [DATA_LEN-1:0] feature_idx;
    logic                feature_valid;
    logic [DATA_LEN-1:0] feature_data;
    logic                label_valid;
    logic [1:0]          label;
    logic                err;

    modport master (
        input  start, OPORT, PC, feature_valid, feature_data,
        output core_rstn, page_sel, instr_override, IPORT,
               feature_req, feature_idx, label_valid, label, err
    );

    modport slave (
        output start, OPORT, PC, feature_valid, feature_data,
        input  core_rstn, page_sel, instr_override, IPORT,
               feature_req, feature_idx, label_valid, label, err
    );
endinterface

// File: rtl/dtree_watchdog.sv
// Stall watchdog: counts cycles spent in one FSM state.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : state changed (restart the count)
//   en_i         : counting allowed in the current state
//   expired_o    : TIMEOUT cycles spent without a state change
module dtree_watchdog #(
    parameter int TIMEOUT = 250000,
    parameter int TO_W    = 18
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    logic [TO_W-1:0] cnt_q, cnt_d;

    // The change detector feeding clear_i lags the state register by one
    // cycle, so the cycle in which clear_i is seen is already the first one
    // spent in the new state: restart at 1, not 0.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i) begin
            cnt_d = '0;
        end else if (clear_i) begin
            cnt_d = TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clear_i && (cnt_q == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/dtree_page_sequencer.sv
// Reactive controller for the 4-bit decision-tree core: decodes OPORT[1:0],
// switches instruction ROM pages (resetting the core and forcing BRANCH 0
// until PC wraps to 0), serves feature requests and reports the class label.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : master modport of dtree_page_sequencer_if
//              in : start, OPORT, PC, feature_valid, feature_data
//              out: core_rstn, page_sel, instr_override, IPORT, feature_req,
//                   feature_idx, label_valid, label, err (all registered)
module dtree_page_sequencer
    import dtree_pkg::*;
#(
    parameter int DATA_LEN  = 4,
    parameter int PC_LEN    = 7,
    parameter int INSTR_LEN = 8,
    parameter int TIMEOUT   = 250000,
    parameter int TO_W      = 18
) (
    input  logic                    CLK,
    input  logic                    RST,
    dtree_page_sequencer_if.master  bus
);
    if (INSTR_LEN != $bits(BRANCH0)) begin : g_bad_instr_len
        $error("INSTR_LEN must match the BRANCH0 encoding width");
    end
    if (TIMEOUT >= (1 << TO_W)) begin : g_bad_to_w
        $error("TO_W too narrow for TIMEOUT");
    end

    state_e              state_q, prev_q;
    page_e               page_q;
    logic                core_rstn_q, override_q, req_q, lvalid_q, err_q;
    logic [DATA_LEN-1:0] iport_q, idx_q;
    logic [1:0]          label_q;

    logic [1:0] ol;
    logic       pc_zero;
    logic       wd_expired;

    assign ol      = bus.OPORT[1:0];
    assign pc_zero = (bus.PC == {PC_LEN{1'b0}});

    dtree_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wd (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (state_q != prev_q),
        .en_i      (wd_active(state_q)),
        .expired_o (wd_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            prev_q      <= S_IDLE;
            page_q      <= PAGE_ROOT;
            core_rstn_q <= 1'b0;
            override_q  <= 1'b0;
            req_q       <= 1'b0;
            lvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            iport_q     <= '0;
            idx_q       <= '0;
            label_q     <= LABEL_0;
        end else begin
            prev_q <= state_q;
            if (wd_expired) begin
                state_q     <= S_ERR;
                err_q       <= 1'b1;
                core_rstn_q <= 1'b0;
                override_q  <= 1'b0;
                req_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        core_rstn_q <= 1'b0;
                        if (bus.start) begin
                            page_q  <= PAGE_ROOT;
                            state_q <= S_CRST;
                        end
                    end
                    // Core held in reset for exactly this one cycle.
                    S_CRST: begin
                        core_rstn_q <= 1'b1;
                        if (page_q == PAGE_ROOT) begin
                            state_q <= S_START;
                        end else begin
                            override_q <= 1'b1;
                            state_q    <= S_PAGING;
                        end
                    end
                    // Force BRANCH 0 until the core's PC has wrapped to 0.
                    S_PAGING: begin
                        if (pc_zero) begin
                            override_q <= 1'b0;
                            state_q    <= S_PAGE_RUN;
                        end else begin
                            override_q <= 1'b1;
                        end
                    end
                    S_PAGE_RUN: if (ol == 2'd3) state_q <= S_START;
                    S_START: begin
                        if (ol == 2'd1)      state_q <= S_OP_0;
                        else if (ol == 2'd2) state_q <= S_OTH_0;
                    end
                    S_OTH_0: begin
                        if (ol == 2'd0)      state_q <= S_OTH_2;
                        else if (ol == 2'd1) state_q <= S_OTH_1;
                    end
                    S_OTH_1: if (ol == 2'd2) state_q <= S_FEAT_WAIT;
                    S_OTH_2: begin
                        if (ol == 2'd1 || ol == 2'd2) begin
                            label_q     <= (ol == 2'd1) ? LABEL_0 : LABEL_1;
                            lvalid_q    <= 1'b1;
                            core_rstn_q <= 1'b0;
                            state_q     <= S_DONE;
                        end
                    end
                    S_OP_0: begin
                        if (ol == 2'd0)      state_q <= S_OP_2;
                        else if (ol == 2'd2) state_q <= S_OP_1;
                    end
                    S_OP_1: begin
                        if (ol == 2'd0 || ol == 2'd1) begin
                            page_q      <= (ol == 2'd0) ? PAGE_LEFT : PAGE_RIGHT;
                            core_rstn_q <= 1'b0;
                            state_q     <= S_CRST;
                        end
                    end
                    S_OP_2: begin
                        if (ol == 2'd1 || ol == 2'd2) begin
                            label_q     <= (ol == 2'd1) ? LABEL_3 : LABEL_2;
                            lvalid_q    <= 1'b1;
                            core_rstn_q <= 1'b0;
                            state_q     <= S_DONE;
                        end
                    end
                    // The core has settled OPORT to the feature index by now.
                    S_FEAT_WAIT: begin
                        idx_q   <= bus.OPORT;
                        req_q   <= 1'b1;
                        state_q <= S_FEAT_REQ;
                    end
                    S_FEAT_REQ: begin
                        if (bus.feature_valid) begin
                            iport_q <= bus.feature_data;
                            req_q   <= 1'b0;
                            state_q <= S_FEAT_FETCH;
                        end
                    end
                    S_FEAT_FETCH: if (ol == 2'd3) state_q <= S_START;
                    S_DONE: begin
                        core_rstn_q <= 1'b0;
                        if (bus.start) begin
                            lvalid_q <= 1'b0;
                            page_q   <= PAGE_ROOT;
                            state_q  <= S_CRST;
                        end
                    end
                    S_ERR: begin
                        core_rstn_q <= 1'b0;
                        if (bus.start) begin
                            err_q   <= 1'b0;
                            page_q  <= PAGE_ROOT;
                            state_q <= S_CRST;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.core_rstn      = core_rstn_q;
    assign bus.page_sel       = page_q;
    assign bus.instr_override = override_q;
    assign bus.IPORT          = iport_q;
    assign bus.feature_req    = req_q;
    assign bus.feature_idx    = idx_q;
    assign bus.label_valid    = lvalid_q;
    assign bus.label          = label_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_dtree_page_sequencer.sv
// Directed bench for dtree_page_sequencer: scripted OPORT/PC sequences stand
// in for the core, the bench acts as the feature source, and labels/features
// are checked against a scoreboard of expected values.
module tb_dtree_page_sequencer;
    localparam int DL = 4;
    localparam int PL = 7;

    logic CLK = 1'b0;
    logic RST;

    dtree_page_sequencer_if #(.DATA_LEN(DL), .PC_LEN(PL)) bus ();

    dtree_page_sequencer #(
        .DATA_LEN  (DL),
        .PC_LEN    (PL),
        .INSTR_LEN (8),
        .TIMEOUT   (16),
        .TO_W      (18)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0]    exp_lab_q[$];
    logic [DL-1:0] exp_feat_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_ol(input logic [DL-1:0] v);
        bus.OPORT = v;
        step(1);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic check_label(input string tag);
        logic [1:0] e;
        chk({tag, "_valid"}, bus.label_valid, 1);
        chk({tag, "_sb_depth"}, exp_lab_q.size(), 1);
        if (exp_lab_q.size() != 0) begin
            e = exp_lab_q.pop_front();
            chk({tag, "_label"}, bus.label, e);
        end
        chk({tag, "_core_rstn"}, bus.core_rstn, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int hc;
        logic [DL-1:0] ef;

        RST = 1'b1;
        bus.start = 1'b0;
        bus.OPORT = '0;
        bus.PC = '0;
        bus.feature_valid = 1'b0;
        bus.feature_data = '0;
        step(2);

        // Reset values
        chk("rst_core_rstn", bus.core_rstn, 0);
        chk("rst_page_sel", bus.page_sel, 0);
        chk("rst_override", bus.instr_override, 0);
        chk("rst_iport", bus.IPORT, 0);
        chk("rst_feat_req", bus.feature_req, 0);
        chk("rst_feat_idx", bus.feature_idx, 0);
        chk("rst_label_valid", bus.label_valid, 0);
        chk("rst_label", bus.label, 0);
        chk("rst_err", bus.err, 0);
        RST = 1'b0;
        step(1);
        chk("idle_core_rstn", bus.core_rstn, 0);

        // Root path: 2,0,1 -> label 0
        pulse_start();
        chk("crst_core_rstn", bus.core_rstn, 0);
        chk("crst_page_sel", bus.page_sel, 0);
        step(1);
        chk("start_core_rstn", bus.core_rstn, 1);
        apply_ol(2);
        apply_ol(0);
        exp_lab_q.push_back(2'd0);
        apply_ol(1);
        check_label("root_l0");
        bus.OPORT = '0;

        // feature_valid is ignored while not requesting
        bus.feature_valid = 1'b1;
        bus.feature_data = 4'h5;
        step(1);
        bus.feature_valid = 1'b0;
        chk("ignored_valid_iport", bus.IPORT, 0);
        chk("done_holds_valid", bus.label_valid, 1);

        // OP path: 1,0,2 -> label 2 then 1,0,1 -> label 3
        pulse_start();
        chk("restart_label_valid", bus.label_valid, 0);
        step(1);
        apply_ol(1);
        apply_ol(0);
        exp_lab_q.push_back(2'd2);
        apply_ol(2);
        check_label("op_l2");
        pulse_start();
        step(1);
        apply_ol(1);
        apply_ol(0);
        exp_lab_q.push_back(2'd3);
        apply_ol(1);
        check_label("op_l3");

        // Feature handshake: idx 6, source answers 3 cycles late with 0xA
        pulse_start();
        step(1);
        apply_ol(2);
        apply_ol(1);
        apply_ol(2);
        exp_feat_q.push_back(4'h6);
        exp_feat_q.push_back(4'hA);
        bus.OPORT = 4'b0110;
        step(1);
        ef = exp_feat_q.pop_front();
        chk("feat_idx", bus.feature_idx, ef);
        hc = 0;
        for (int i = 0; i < 20 && bus.feature_req; i++) begin
            hc++;
            if (hc == 4) begin
                bus.feature_valid = 1'b1;
                bus.feature_data = 4'hA;
            end
            step(1);
        end
        bus.feature_valid = 1'b0;
        bus.feature_data = '0;
        chk("feat_req_cycles", hc, 4);
        chk("feat_req_dropped", bus.feature_req, 0);
        ef = exp_feat_q.pop_front();
        chk("feat_iport", bus.IPORT, ef);
        step(2);
        apply_ol(3);
        apply_ol(2);
        apply_ol(0);
        exp_lab_q.push_back(2'd0);
        apply_ol(1);
        check_label("after_feat");
        chk("iport_held", bus.IPORT, 4'hA);

        // Page switch to LEFT: 1,2,0
        pulse_start();
        step(1);
        apply_ol(1);
        apply_ol(2);
        bus.PC = 7'd5;
        apply_ol(0);
        chk("left_page_sel", bus.page_sel, 1);
        chk("left_crst_rstn", bus.core_rstn, 0);
        step(1);
        chk("left_rstn_back", bus.core_rstn, 1);
        chk("left_ovr_pc5", bus.instr_override, 1);
        bus.PC = 7'd6;
        step(1);
        chk("left_ovr_pc6", bus.instr_override, 1);
        bus.PC = 7'd0;
        step(1);
        chk("left_ovr_pc0", bus.instr_override, 0);
        apply_ol(3);
        apply_ol(2);
        apply_ol(0);
        exp_lab_q.push_back(2'd1);
        apply_ol(2);
        check_label("left_run");
        chk("left_page_kept", bus.page_sel, 1);

        // Page switch to RIGHT: 1,2,1
        pulse_start();
        chk("right_restart_page", bus.page_sel, 0);
        step(1);
        apply_ol(1);
        apply_ol(2);
        bus.PC = 7'd3;
        apply_ol(1);
        chk("right_page_sel", bus.page_sel, 2);
        step(1);
        chk("right_ovr_pc3", bus.instr_override, 1);
        bus.PC = 7'd0;
        step(1);
        chk("right_ovr_pc0", bus.instr_override, 0);
        apply_ol(3);
        apply_ol(1);
        apply_ol(0);
        exp_lab_q.push_back(2'd2);
        apply_ol(2);
        check_label("right_run");

        // Watchdog: hold ol=0 in START for 16 cycles
        bus.OPORT = '0;
        pulse_start();
        step(1);
        step(15);
        chk("wd_err_early", bus.err, 0);
        chk("wd_rstn_early", bus.core_rstn, 1);
        step(1);
        chk("wd_err", bus.err, 1);
        chk("wd_err_rstn", bus.core_rstn, 0);
        step(3);
        chk("wd_err_hold", bus.err, 1);
        pulse_start();
        chk("wd_err_clear", bus.err, 0);
        chk("wd_clear_page", bus.page_sel, 0);
        step(1);
        chk("wd_recover_rstn", bus.core_rstn, 1);

        // Asynchronous reset in the middle of a feature request
        apply_ol(2);
        apply_ol(1);
        apply_ol(2);
        bus.OPORT = 4'b1001;
        step(1);
        chk("ar_req_before", bus.feature_req, 1);
        chk("ar_idx_before", bus.feature_idx, 4'h9);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_feat_req", bus.feature_req, 0);
        chk("ar_feat_idx", bus.feature_idx, 0);
        chk("ar_iport", bus.IPORT, 0);
        chk("ar_core_rstn", bus.core_rstn, 0);
        chk("ar_override", bus.instr_override, 0);
        chk("ar_label", bus.label, 0);
        chk("ar_label_valid", bus.label_valid, 0);
        chk("ar_err", bus.err, 0);
        #2;
        RST = 1'b0;
        bus.OPORT = '0;
        step(2);
        chk("ar_idle_rstn", bus.core_rstn, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
